// File: rtl/minisys_pkg.sv
// minisys_pkg
//   Shared definitions for the minisys fetch front end.
//   - RESET_VECTOR / EXC_VECTOR : default reset and exception-entry addresses
//   - pcgen_state_t             : next-PC generator control states
//   - redir_src_t               : which source the next PC was selected from
//   - align_word()              : forces a byte address onto a word boundary
package minisys_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_F000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } pcgen_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_J,
    SRC_JR,
    SRC_BR,
    SRC_ERET,
    SRC_EXC
  } redir_src_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/minisys_pcgen_sel.sv
// pcgen_sel
//   Combinational next-PC selector: priority encoder plus target mux.
//   Priority, highest first: exc_req, eret_en, br_taken, jr_en, j_en, stall,
//   sequential.
//   Inputs : pc (current fetch PC), stall, br_taken/br_target, j_en/j_target,
//            jr_en/jr_target, exc_req, eret_en/epc
//   Outputs: next_pc      - word-aligned redirect target, pc held, or pc+4
//            redir        - a control-flow redirect was selected
//            src          - selected source
//            tgt_misalign - raw redirect target had nonzero low bits
module pcgen_sel
  import minisys_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = minisys_pkg::EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_en,
  input  logic [31:0] j_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_en,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        redir,
  output redir_src_t  src,
  output logic        tgt_misalign
);

  logic [31:0] target;

  always_comb begin
    target = 32'h0000_0000;
    src    = SRC_SEQ;
    if (exc_req) begin
      target = EXC_VECTOR;
      src    = SRC_EXC;
    end else if (eret_en) begin
      target = epc;
      src    = SRC_ERET;
    end else if (br_taken) begin
      target = br_target;
      src    = SRC_BR;
    end else if (jr_en) begin
      target = jr_target;
      src    = SRC_JR;
    end else if (j_en) begin
      target = j_target;
      src    = SRC_J;
    end else if (stall) begin
      src    = SRC_HOLD;
    end
  end

  // Redirects outrank stall: the stalled younger instruction is wrong-path.
  assign redir        = exc_req | eret_en | br_taken | jr_en | j_en;
  assign tgt_misalign = redir & (|target[1:0]);

  always_comb begin
    next_pc = pc + 32'd4;
    if (redir)      next_pc = align_word(target);
    else if (stall) next_pc = pc;
  end

endmodule

// File: rtl/minisys_pcgen.sv
// minisys_pcgen
//   Next-PC generator. Owns the architectural fetch PC, applies redirects
//   from EX and CP0, honours hazard stalls, and flags the wrong-path word
//   that decode must discard after every redirect.
//   Inputs : clk, rst (async, active-high), stall, br_taken/br_target,
//            j_en/j_target, jr_en/jr_target, exc_req, eret_en/epc
//   Outputs: pc (registered), pcplus4 (pc+4, combinational), pc_valid,
//            flush_if, misalign (registered pulse), redirect_cnt (saturating)
module minisys_pcgen
  import minisys_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = minisys_pkg::RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = minisys_pkg::EXC_VECTOR,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             j_en,
  input  logic [31:0]      j_target,
  input  logic             jr_en,
  input  logic [31:0]      jr_target,
  input  logic             exc_req,
  input  logic             eret_en,
  input  logic [31:0]      epc,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  output logic             pc_valid,
  output logic             flush_if,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  pcgen_state_t state;
  logic [31:0]  sel_pc;
  logic         sel_redir;
  redir_src_t   sel_src;
  logic         sel_misalign;

  assign pcplus4 = pc + 32'd4;

  pcgen_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_sel (
    .pc           (pc),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .j_en         (j_en),
    .j_target     (j_target),
    .jr_en        (jr_en),
    .jr_target    (jr_target),
    .exc_req      (exc_req),
    .eret_en      (eret_en),
    .epc          (epc),
    .next_pc      (sel_pc),
    .redir        (sel_redir),
    .src          (sel_src),
    .tgt_misalign (sel_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      flush_if     <= 1'b1;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      case (state)
        // One settling cycle: pc held and all redirect inputs ignored, so
        // the first real fetch is at RESET_VECTOR.
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
          flush_if <= 1'b0;
          misalign <= 1'b0;
        end
        RUN, REDIR: begin
          pc_valid <= 1'b1;
          if (sel_redir) begin
            state    <= REDIR;
            pc       <= sel_pc;
            flush_if <= 1'b1;
            misalign <= sel_misalign;
            if (!(&redirect_cnt))
              redirect_cnt <= redirect_cnt + CNT_W'(1);
          end else begin
            state    <= RUN;
            flush_if <= 1'b0;
            misalign <= 1'b0;
            case (sel_src)
              SRC_HOLD: pc <= pc;
              SRC_SEQ:  pc <= pcplus4;
              default:  pc <= sel_pc;
            endcase
          end
        end
        default: begin
          state    <= BOOT;
          pc       <= RESET_VECTOR;
          pc_valid <= 1'b0;
          flush_if <= 1'b1;
          misalign <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/minisys_pcgen.md
Name: minisys_pcgen

Overview:
- Next-PC generator. Owns the architectural fetch PC and drives `pc` into the fetch stage every cycle.
- Selects between sequential, branch, jump, jump-register, exception-entry and ERET targets, and honours hazard-unit stalls.
- Emits a one-cycle `flush_if` so the decode stage discards the wrong-path word latched at a redirect edge.
- Sits upstream of the fetch stage; its inputs come from the hazard unit, the EX branch resolver and CP0.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_F000, exception entry address.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC.
- br_taken  in  1  EX: conditional branch taken.
- br_target  in  32  branch target.
- j_en  in  1  J/JAL resolved.
- j_target  in  32  jump target (already concatenated).
- jr_en  in  1  JR/JALR resolved.
- jr_target  in  32  register target.
- exc_req  in  1  CP0: take exception.
- eret_en  in  1  CP0: return from exception.
- epc  in  32  return address.
- pc  out  32  current fetch PC (registered).
- pcplus4  out  32  pc+4, combinational, modulo 2^32.
- pc_valid  out  1  fetch address is valid.
- flush_if  out  1  kill the instruction entering decode.
- misalign  out  1  registered pulse: last accepted redirect target had [1:0]!=0.
- redirect_cnt  out  CNT_W  accepted redirects, saturating.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - pc=RESET_VECTOR, state=BOOT, pc_valid=0, flush_if=1, misalign=0, redirect_cnt=0.
- States BOOT, RUN, REDIR, all registered.
- BOOT (exactly 1 cycle after reset release):
  - pc held, all redirect inputs ignored.
  - Next: RUN, with pc_valid=1 and flush_if=0. The first fetch is at RESET_VECTOR.
- Select priority (highest first): exc_req > eret_en > br_taken > jr_en > j_en > stall > sequential.
  - exc_req → EXC_VECTOR.
  - eret_en → epc.
  - br_taken → br_target.
  - jr_en → jr_target.
  - j_en → j_target.
  - stall → pc held.
  - sequential → pc+4.
- Redirects override stall, because the stalled younger instruction is on the wrong path.
- Accepting a redirect, in RUN or REDIR:
  - At the edge: pc <= {target[31:2],2'b00}; misalign <= |target[1:0]; redirect_cnt increments unless it is all-ones.
  - State → REDIR; flush_if=1 for that following cycle.
- REDIR with no new redirect:
  - Next: RUN, flush_if=0, pc <= pc+4 (or held if stall).
  - Back-to-back redirects keep the block in REDIR with flush_if continuously 1; each one is counted.
- misalign:
  - Cleared on the next cycle without a redirect.
  - Misalignment never blocks the redirect; the aligned PC is always used.
- Wrap-around: pc=32'hFFFF_FFFC sequential → 32'h0000_0000, no flag; pcplus4 likewise.
- Stall in RUN with no redirect: pc and flush_if unchanged (flush_if=0).
- pc_valid is 0 only in BOOT.
- Latency: one clock from a redirect input to pc and flush_if. pcplus4 has zero latency relative to pc.

Decomposition:
- Shared package minisys_pkg:
  - Constants RESET_VECTOR and EXC_VECTOR.
  - pcgen_state_t enum {BOOT, RUN, REDIR}.
  - redir_src_t enum {SRC_SEQ, SRC_HOLD, SRC_J, SRC_JR, SRC_BR, SRC_ERET, SRC_EXC}.
- One combinational sub-module, pcgen_sel: priority encoder plus target mux, producing next_pc, redir and src. The top keeps the state, pc, counter and flag registers.

Test Plan:
- Reset, release, run 3 cycles:
  - pc = 0, 0 (BOOT), 4, 8.
  - pc_valid=0 then 1; flush_if=1 only in BOOT.
- br_taken=1 with br_target=32'h0000_0100 at pc=8:
  - Next cycle pc=0x100, flush_if=1, redirect_cnt=1.
  - Then pc=0x104, flush_if=0.
- exc_req, br_taken and stall all high in the same cycle: pc=EXC_VECTOR (0xF000), flush_if=1; the branch is lost.
- jr_target=32'h0000_0203: pc=0x200 and misalign=1 for one cycle.
- Stall sequence and wrap-around:
  - Stall for 3 cycles at pc=0x40: pc stays 0x40, flush_if=0.
  - pc forced to 0xFFFF_FFFC via eret: next sequential pc=0.
- 70000 consecutive j_en redirects: redirect_cnt saturates at 16'hFFFF; flush_if stays 1 throughout.
- Assert rst during REDIR: pc=0 and state BOOT immediately, without waiting for a clock edge.
